// File: rtl/param_updown_counter.sv
// Parametrised modulo-MODULUS up/down counter with load, clear and optional saturation.
// Provides a combinational terminal-count flag and a registered overflow pulse for cascading.
module param_updown_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MODULUS  = 256,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync_clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             count_down,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             at_bound;

  // Bound depends on the direction currently requested, not the last step taken.
  assign at_bound = count_down ? (count_q == '0) : (count_q == MaxCount);

  always_comb begin
    count_d    = count_q;
    overflow_d = 1'b0;
    if (sync_clear) begin
      count_d = count_down ? MaxCount : '0;
    end else if (load) begin
      count_d = (load_value > MaxCount) ? MaxCount : load_value;
    end else if (enable) begin
      if (at_bound) begin
        overflow_d = 1'b1;
        if (!SATURATE) begin
          count_d = count_down ? MaxCount : '0;
        end
      end else begin
        count_d = count_down ? (count_q - One) : (count_q + One);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign terminal = at_bound;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: default, mod-10 and saturating mod-16 instances.
// Every expected value below is hand-computed from the counter's intended behaviour.
module tb_param_updown_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: defaults (WIDTH 8, MODULUS 256, wrap)
  logic       a_sync_clear, a_load, a_enable, a_count_down;
  logic [7:0] a_load_value, a_count;
  logic       a_terminal, a_overflow;
  // Instance B: WIDTH 4, MODULUS 10, wrap
  logic       b_sync_clear, b_load, b_enable, b_count_down;
  logic [3:0] b_load_value, b_count;
  logic       b_terminal, b_overflow;
  // Instance C: WIDTH 4, MODULUS 16, saturate
  logic       c_sync_clear, c_load, c_enable, c_count_down;
  logic [3:0] c_load_value, c_count;
  logic       c_terminal, c_overflow;

  int tests  = 0;
  int failed = 0;

  param_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(reset), .sync_clear(a_sync_clear), .load(a_load),
    .load_value(a_load_value), .enable(a_enable), .count_down(a_count_down),
    .count(a_count), .terminal(a_terminal), .overflow(a_overflow)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .sync_clear(b_sync_clear), .load(b_load),
    .load_value(b_load_value), .enable(b_enable), .count_down(b_count_down),
    .count(b_count), .terminal(b_terminal), .overflow(b_overflow)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b1)) dut_c (
    .clk(clk), .reset(reset), .sync_clear(c_sync_clear), .load(c_load),
    .load_value(c_load_value), .enable(c_enable), .count_down(c_count_down),
    .count(c_count), .terminal(c_terminal), .overflow(c_overflow)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [3:0] exp_cnt [12];
    exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

    reset = 1'b0;
    {a_sync_clear, a_load, a_enable, a_count_down, a_load_value} = '0;
    {b_sync_clear, b_load, b_enable, b_count_down, b_load_value} = '0;
    {c_sync_clear, c_load, c_enable, c_count_down, c_load_value} = '0;

    // Reset state before any clock edge
    #2;
    check("rst_a_count", a_count, 0);
    check("rst_a_ovf", a_overflow, 0);
    check("rst_b_count", b_count, 0);
    check("rst_c_count", c_count, 0);
    tick();
    tick();
    reset = 1'b1;

    // Bring A to 37, then reset asynchronously between edges
    a_load_value = 8'd35;
    a_load = 1'b1;
    tick();
    check("a_load35", a_count, 35);
    a_load = 1'b0;
    a_enable = 1'b1;
    tick();
    tick();
    a_enable = 1'b0;
    check("a_count37", a_count, 37);
    reset = 1'b0;
    #1;
    check("async_rst_count", a_count, 0);
    check("async_rst_ovf", a_overflow, 0);
    reset = 1'b1;

    // Terminal tracks count_down combinationally
    a_count_down = 1'b1;
    #1;
    check("a_term_down_at0", a_terminal, 1);
    a_count_down = 1'b0;
    #1;
    check("a_term_up_at0", a_terminal, 0);

    // Priority: load beats enable, clear beats load
    a_load_value = 8'd5;
    a_load = 1'b1;
    a_enable = 1'b1;
    tick();
    check("prio_load", a_count, 5);
    a_sync_clear = 1'b1;
    a_count_down = 1'b1;
    tick();
    check("prio_clear_down", a_count, 255);
    check("prio_clear_ovf", a_overflow, 0);
    check("a_term_down_255", a_terminal, 0);

    // Default modulus wraps 255 -> 0, then reset kills the pending overflow
    a_sync_clear = 1'b0;
    a_load = 1'b0;
    a_count_down = 1'b0;
    #1;
    check("a_term_up_255", a_terminal, 1);
    tick();
    check("a_wrap_count", a_count, 0);
    check("a_wrap_ovf", a_overflow, 1);
    a_enable = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_kills_ovf", a_overflow, 0);
    reset = 1'b1;

    // MODULUS=10 counting up for 12 edges
    b_enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("m10_up_count_%0d", k), b_count, exp_cnt[k]);
      check($sformatf("m10_up_ovf_%0d", k), b_overflow, (k == 9) ? 1 : 0);
      check($sformatf("m10_up_term_%0d", k), b_terminal, (k == 8) ? 1 : 0);
    end
    b_enable = 1'b0;

    // MODULUS=10 counting down from 0
    b_sync_clear = 1'b1;
    tick();
    check("m10_clear_up", b_count, 0);
    b_sync_clear = 1'b0;
    b_count_down = 1'b1;
    #1;
    check("m10_term_down0", b_terminal, 1);
    b_enable = 1'b1;
    tick();
    check("m10_dn_count9", b_count, 9);
    check("m10_dn_ovf1", b_overflow, 1);
    check("m10_dn_term9", b_terminal, 0);
    tick();
    check("m10_dn_count8", b_count, 8);
    check("m10_dn_ovf0", b_overflow, 0);
    b_enable = 1'b0;
    tick();
    check("m10_hold8", b_count, 8);
    check("m10_hold_ovf", b_overflow, 0);

    // Out-of-range load clamps to MODULUS-1
    b_count_down = 1'b0;
    b_load_value = 4'd12;
    b_load = 1'b1;
    tick();
    check("m10_clamp", b_count, 9);
    check("m10_clamp_ovf", b_overflow, 0);
    check("m10_clamp_term", b_terminal, 1);
    b_load = 1'b0;
    b_enable = 1'b1;
    tick();
    check("m10_clamp_wrap", b_count, 0);
    check("m10_clamp_wrap_ovf", b_overflow, 1);
    tick();
    check("m10_after_wrap", b_count, 1);
    check("m10_after_wrap_ovf", b_overflow, 0);
    b_enable = 1'b0;

    // Saturate mode holds at 15 with repeated overflow pulses
    c_load_value = 4'd15;
    c_load = 1'b1;
    tick();
    c_load = 1'b0;
    c_enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("sat_up_count_%0d", k), c_count, 15);
      check($sformatf("sat_up_ovf_%0d", k), c_overflow, 1);
      check($sformatf("sat_up_term_%0d", k), c_terminal, 1);
    end
    c_enable = 1'b0;
    tick();
    check("sat_idle_count", c_count, 15);
    check("sat_idle_ovf", c_overflow, 0);

    // Saturate mode holds at 0 counting down
    c_sync_clear = 1'b1;
    tick();
    check("sat_clear_up", c_count, 0);
    c_sync_clear = 1'b0;
    c_count_down = 1'b1;
    c_enable = 1'b1;
    tick();
    check("sat_dn_count", c_count, 0);
    check("sat_dn_ovf", c_overflow, 1);
    c_enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
